// File: rtl/svm_linear_multi.sv
// Linear-kernel SVM classifier: one feature vector per label, LANES MACs per cycle,
// sign of (bias + w.x) per label collected into a result vector.
module svm_linear_multi #(
    parameter int NBITS      = 8,
    parameter int F_WIDTH    = 4,
    parameter int NUM_LABELS = 2,
    parameter int LANES      = 1,
    parameter int BIAS_SHIFT = 0,
    localparam int BEATS     = F_WIDTH / LANES,
    localparam int ACC_WIDTH = 2 * NBITS + $clog2(F_WIDTH + 1) + 1,
    localparam int CFG_DEPTH = NUM_LABELS * (F_WIDTH + 1),
    localparam int CFG_AW    = $clog2(CFG_DEPTH),
    localparam int LOG_L     = (NUM_LABELS > 1) ? $clog2(NUM_LABELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NBITS*F_WIDTH-1:0]  in_features,
    input  logic                      fin_valid,
    output logic                      fin_ready,
    output logic [LOG_L-1:0]          fin_label,
    input  logic                      cfg_we,
    input  logic [CFG_AW-1:0]         cfg_addr,
    input  logic [NBITS-1:0]          cfg_data,
    output logic                      cfg_ready,
    output logic [NUM_LABELS-1:0]     labels,
    output logic                      dout_valid,
    input  logic                      dout_ready
);

    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        S_ACCEPT,
        S_MAC,
        S_OUT
    } state_t;

    state_t                       state_q;
    logic [LOG_L-1:0]             lbl_q;
    logic [BEAT_W-1:0]            beat_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [ACC_WIDTH-1:0]  acc_d;
    logic [NUM_LABELS-1:0]        labels_q;
    logic signed [NBITS-1:0]      x_q    [F_WIDTH];
    logic signed [NBITS-1:0]      coef_q [CFG_DEPTH];

    logic signed [NBITS-1:0]      w_cur  [F_WIDTH];
    logic signed [NBITS-1:0]      b_cur;
    logic signed [NBITS-1:0]      lane_w [LANES];
    logic signed [NBITS-1:0]      lane_x [LANES];
    logic signed [2*NBITS-1:0]    lane_p [LANES];
    logic signed [ACC_WIDTH-1:0]  beat_sum;
    logic signed [ACC_WIDTH-1:0]  bias_ext;
    logic                         last_beat;
    logic                         cfg_wr;

    assign fin_ready  = (state_q == S_ACCEPT);
    assign fin_label  = lbl_q;
    assign cfg_ready  = (state_q == S_ACCEPT) && (lbl_q == '0);
    assign labels     = labels_q;
    assign dout_valid = (state_q == S_OUT);
    assign cfg_wr     = cfg_we && cfg_ready;
    assign last_beat  = (beat_q == BEAT_W'(BEATS - 1));

    // Coefficient row of the current label, selected with constant indices only.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        b_cur = '0;
        for (int f = 0; f < F_WIDTH; f++) w_cur[f] = '0;
        for (int l = 0; l < NUM_LABELS; l++) begin
            if (lbl_q == LOG_L'(l)) begin
                for (int f = 0; f < F_WIDTH; f++) w_cur[f] = coef_q[l*(F_WIDTH+1) + f];
                b_cur = coef_q[l*(F_WIDTH+1) + F_WIDTH];
            end
        end
    end

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_w[i] = '0;
            lane_x[i] = '0;
            for (int b = 0; b < BEATS; b++) begin
                if (beat_q == BEAT_W'(b)) begin
                    lane_w[i] = w_cur[b*LANES + i];
                    lane_x[i] = x_q[b*LANES + i];
                end
            end
            lane_p[i] = lane_w[i] * lane_x[i];
            beat_sum  = beat_sum + ACC_WIDTH'(lane_p[i]);
        end
    end

    assign bias_ext = ACC_WIDTH'(b_cur) <<< BIAS_SHIFT;
    assign acc_d    = acc_q + beat_sum;

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_ACCEPT;
            lbl_q    <= '0;
            beat_q   <= '0;
            acc_q    <= '0;
            labels_q <= '0;
            // NOTE: the coefficient file is reset on purpose: an unprogrammed engine must see zeros.
            for (int i = 0; i < CFG_DEPTH; i++) coef_q[i] <= '0;
        end else begin
            // Out-of-range addresses match no entry and are dropped.
            for (int i = 0; i < CFG_DEPTH; i++) begin
                if (cfg_wr && (cfg_addr == CFG_AW'(i))) coef_q[i] <= cfg_data;
            end

            case (state_q)
                S_ACCEPT: begin
                    if (fin_valid) begin
                        for (int f = 0; f < F_WIDTH; f++) x_q[f] <= in_features[f*NBITS +: NBITS];
                        acc_q   <= bias_ext;
                        beat_q  <= '0;
                        state_q <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_q  <= acc_d;
                    beat_q <= beat_q + 1'b1;
                    if (last_beat) begin
                        for (int k = 0; k < NUM_LABELS; k++) begin
                            if (lbl_q == LOG_L'(k)) labels_q[k] <= ~acc_d[ACC_WIDTH-1];
                        end
                        if (lbl_q == LOG_L'(NUM_LABELS - 1)) begin
                            state_q <= S_OUT;
                        end else begin
                            lbl_q   <= lbl_q + 1'b1;
                            state_q <= S_ACCEPT;
                        end
                    end
                end
                S_OUT: begin
                    if (dout_ready) begin
                        lbl_q   <= '0;
                        state_q <= S_ACCEPT;
                    end
                end
                default: state_q <= S_ACCEPT;
            endcase
        end
    end

endmodule

// File: tb/tb_svm_linear_multi.sv
// Directed bench for svm_linear_multi: LANES=1 instance for most scenarios,
// LANES=2 instance sharing clock, reset, features and coefficient bus.
module tb_svm_linear_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_features = '0;
    logic        fin_valid = 1'b0, fin_valid2 = 1'b0;
    logic        dout_ready = 1'b1, dout_ready2 = 1'b1;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [7:0]  cfg_data = '0;

    logic        fin_ready, fin_ready2;
    logic        fin_label, fin_label2;
    logic        cfg_ready, cfg_ready2;
    logic [1:0]  labels, labels2;
    logic        dout_valid, dout_valid2;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    svm_linear_multi #(.NBITS(8), .F_WIDTH(4), .NUM_LABELS(2), .LANES(1), .BIAS_SHIFT(0)) dut (
        .clk(clk), .rst(rst), .in_features(in_features), .fin_valid(fin_valid),
        .fin_ready(fin_ready), .fin_label(fin_label), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_ready(cfg_ready), .labels(labels), .dout_valid(dout_valid),
        .dout_ready(dout_ready)
    );

    svm_linear_multi #(.NBITS(8), .F_WIDTH(4), .NUM_LABELS(2), .LANES(2), .BIAS_SHIFT(0)) dut2 (
        .clk(clk), .rst(rst), .in_features(in_features), .fin_valid(fin_valid2),
        .fin_ready(fin_ready2), .fin_label(fin_label2), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_ready(cfg_ready2), .labels(labels2), .dout_valid(dout_valid2),
        .dout_ready(dout_ready2)
    );

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cfg_write(input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_addr = 4'(addr);
        cfg_data = 8'(data);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic program_label(input int lbl, input int w0, input int w1,
                                 input int w2, input int w3, input int b);
        int base;
        base = lbl * 5;
        cfg_write(base + 0, w0);
        cfg_write(base + 1, w1);
        cfg_write(base + 2, w2);
        cfg_write(base + 3, w3);
        cfg_write(base + 4, b);
    endtask

    task automatic program_positive();
        program_label(0, 1, 2, 3, 4, -30);
        program_label(1, -1, -1, -1, -1, 5);
    endtask

    // Returns at the falling edge right after the accepting rising edge.
    task automatic send_vec(input bit sel, input logic [31:0] feat);
        int n;
        n = 0;
        while (((sel ? fin_ready2 : fin_ready) !== 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            tests_run++;
            tests_failed++;
            $display("FAIL fin_ready_timeout: fin_ready stayed low for %0d cycles, required high", n);
        end
        in_features = feat;
        if (sel) fin_valid2 = 1'b1; else fin_valid = 1'b1;
        @(negedge clk);
        fin_valid  = 1'b0;
        fin_valid2 = 1'b0;
    endtask

    task automatic wait_dout(input bit sel, output int n);
        n = 0;
        while (((sel ? dout_valid2 : dout_valid) !== 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_pair(input bit sel, input logic [31:0] x0, input logic [31:0] x1,
                            output int lat, output logic [1:0] lab);
        send_vec(sel, x0);
        send_vec(sel, x1);
        wait_dout(sel, lat);
        lab = sel ? labels2 : labels;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (fin_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_fin_ready: got %b want 1", fin_ready); end
        tests_run++;
        if (fin_label !== 1'b0) begin tests_failed++; $display("FAIL reset_fin_label: got %b want 0", fin_label); end
        tests_run++;
        if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
        tests_run++;
        if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid); end
        tests_run++;
        if (labels !== 2'b00) begin tests_failed++; $display("FAIL reset_labels: got %b want 00", labels); end
    endtask

    task automatic test_positive();
        int lat;
        program_positive();
        send_vec(1'b0, pack4(1, 2, 3, 4));
        tests_run++;
        if (fin_label !== 1'b0) begin tests_failed++; $display("FAIL pos_label_during_mac: got %b want 0", fin_label); end
        tests_run++;
        if (fin_ready !== 1'b0 || cfg_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL pos_ready_during_mac: fin_ready=%b cfg_ready=%b want 0 0", fin_ready, cfg_ready);
        end
        send_vec(1'b0, pack4(1, 1, 1, 1));
        tests_run++;
        if (fin_label !== 1'b1) begin tests_failed++; $display("FAIL pos_label1_index: got %b want 1", fin_label); end
        wait_dout(1'b0, lat);
        tests_run++;
        if (lat != 4) begin tests_failed++; $display("FAIL pos_latency: got %0d cycles want 4", lat); end
        tests_run++;
        if (labels !== 2'b11) begin tests_failed++; $display("FAIL pos_labels: got %b want 11", labels); end
        @(negedge clk);
        tests_run++;
        if (dout_valid !== 1'b0 || fin_label !== 1'b0) begin
            tests_failed++;
            $display("FAIL pos_after_handshake: dout_valid=%b fin_label=%b want 0 0", dout_valid, fin_label);
        end
    endtask

    task automatic test_negative();
        int lat;
        logic [1:0] lab;
        run_pair(1'b0, pack4(1, 2, 3, 3), pack4(2, 2, 2, 2), lat, lab);
        tests_run++;
        if (lab !== 2'b00) begin tests_failed++; $display("FAIL neg_labels: got %b want 00", lab); end
        @(negedge clk);
    endtask

    task automatic test_extremes();
        int lat;
        logic [1:0] lab;
        // label0: 4*16384+127 = 65663 -> 1 ; label1: 4*(-16256)-128 = -65152 -> 0
        program_label(0, -128, -128, -128, -128, 127);
        program_label(1, 127, 127, 127, 127, -128);
        run_pair(1'b0, pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -128), lat, lab);
        tests_run++;
        if (lab !== 2'b01) begin tests_failed++; $display("FAIL extremes_labels: got %b want 01", lab); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat;
        logic [1:0] lab;
        program_positive();
        dout_ready = 1'b0;
        run_pair(1'b0, pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), lat, lab);
        tests_run++;
        if (lab !== 2'b11) begin tests_failed++; $display("FAIL bp_labels: got %b want 11", lab); end
        for (int c = 0; c < 10; c++) begin
            tests_run++;
            if (dout_valid !== 1'b1 || labels !== 2'b11 || fin_ready !== 1'b0 || cfg_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold_c%0d: dout_valid=%b labels=%b fin_ready=%b cfg_ready=%b want 1 11 0 0",
                         c, dout_valid, labels, fin_ready, cfg_ready);
            end
            // Attempt to overwrite label0 bias with -31 while writes are blocked.
            cfg_we   = (c == 3);
            cfg_addr = 4'd4;
            cfg_data = 8'(-31);
            @(negedge clk);
        end
        cfg_we = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_release: dout_valid=%b want 0", dout_valid); end
        run_pair(1'b0, pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), lat, lab);
        tests_run++;
        if (lab !== 2'b11) begin tests_failed++; $display("FAIL bp_blocked_write: got %b want 11", lab); end
        @(negedge clk);
    endtask

    task automatic test_mid_mac_reset();
        int lat;
        logic [1:0] lab;
        send_vec(1'b0, pack4(1, 2, 3, 4));
        send_vec(1'b0, pack4(1, 1, 1, 1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (fin_ready !== 1'b1 || fin_label !== 1'b0 || cfg_ready !== 1'b1 ||
            dout_valid !== 1'b0 || labels !== 2'b00) begin
            tests_failed++;
            $display("FAIL midmac_reset_state: fin_ready=%b fin_label=%b cfg_ready=%b dout_valid=%b labels=%b want 1 0 1 0 00",
                     fin_ready, fin_label, cfg_ready, dout_valid, labels);
        end
        run_pair(1'b0, pack4(1, 2, 3, 3), pack4(2, 2, 2, 2), lat, lab);
        tests_run++;
        if (lab !== 2'b11) begin tests_failed++; $display("FAIL midmac_unprogrammed: got %b want 11", lab); end
        @(negedge clk);
    endtask

    task automatic test_lanes2();
        int lat;
        logic [1:0] lab;
        program_positive();
        run_pair(1'b1, pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), lat, lab);
        tests_run++;
        if (lat != 2) begin tests_failed++; $display("FAIL lanes2_latency: got %0d cycles want 2", lat); end
        tests_run++;
        if (lab !== 2'b11) begin tests_failed++; $display("FAIL lanes2_labels: got %b want 11", lab); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int t_first, t_second, seen, n;
        t_first = 0; t_second = 0; seen = 0; n = 0;
        in_features = pack4(1, 2, 3, 4);
        fin_valid = 1'b1;
        while (seen < 2 && n < 100) begin
            @(negedge clk);
            n++;
            if (dout_valid === 1'b1) begin
                if (seen == 0) t_first = n; else t_second = n;
                seen++;
                tests_run++;
                if (labels !== 2'b01) begin tests_failed++; $display("FAIL b2b_labels: got %b want 01", labels); end
            end
        end
        fin_valid = 1'b0;
        tests_run++;
        if (seen != 2 || (t_second - t_first) != 11) begin
            tests_failed++;
            $display("FAIL b2b_throughput: results=%0d period=%0d want 2 results 11 cycles apart",
                     seen, t_second - t_first);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_positive();
        test_negative();
        test_extremes();
        test_backpressure();
        test_mid_mac_reset();
        test_lanes2();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
